// File: rtl/debounce_sync.sv
// Synchroniser plus debouncer: a_clean only flips after the synchronised input has differed for STABLE_CYCLES edges.
// Optional macro DEBOUNCE_GLITCH_CNT_EN instantiates the saturating glitch counter; otherwise glitch_cnt is tied to 0.
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter bit INIT_LEVEL    = 1'b0,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_raw,
  output logic                a_clean,
  output logic                stable,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CHECK = 1'b1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [0:0]             state, state_d;
  logic [CW-1:0]          count, count_d;
  logic                   clean_d, stable_d;

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], a_raw};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  always_comb begin
    state_d  = state;
    count_d  = count;
    clean_d  = a_clean;
    stable_d = stable;
    case (state)
      IDLE: begin
        if (s != a_clean) begin
          state_d  = CHECK;
          count_d  = CW'(1);
          stable_d = 1'b0;
        end else begin
          count_d = '0;
        end
      end
      CHECK: begin
        if (s != a_clean) begin
          // The flip lands on the edge where the run length reaches STABLE_CYCLES.
          if (count == LAST) begin
            clean_d  = s;
            count_d  = '0;
            stable_d = 1'b1;
            state_d  = IDLE;
          end else begin
            count_d = count + CW'(1);
          end
        end else begin
          state_d  = IDLE;
          count_d  = '0;
          stable_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        count_d  = '0;
        stable_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      a_clean <= INIT_LEVEL;
      stable  <= 1'b1;
    end else begin
      state   <= state_d;
      count   <= count_d;
      a_clean <= clean_d;
      stable  <= stable_d;
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                abort;
  logic [GLITCH_W-1:0] glitch_q;

  // A candidate that bounces back before qualifying counts as one glitch.
  assign abort = (state == CHECK) && (s == a_clean);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= '0;
    end else if (abort && (glitch_q != {GLITCH_W{1'b1}})) begin
      glitch_q <= glitch_q + GLITCH_W'(1);
    end
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: drivers queue expected {a_clean, stable, glitch_cnt(W=8), glitch_cnt(W=2)},
// a monitor pops and compares after each rising edge or on an explicit asynchronous-check event.
module tb_debounce_sync;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  localparam int W = 12;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       a_raw = 1'b0;
  logic       a_clean, stable;
  logic [7:0] gc;
  logic       a_clean2, stable2;
  logic [1:0] gc2;

  debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .INIT_LEVEL(1'b0), .GLITCH_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_raw      (a_raw),
    .a_clean    (a_clean),
    .stable     (stable),
    .glitch_cnt (gc)
  );

  debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .INIT_LEVEL(1'b0), .GLITCH_W(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_raw      (a_raw),
    .a_clean    (a_clean2),
    .stable     (stable2),
    .glitch_cnt (gc2)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks   = 0;
  int           failures = 0;
  int           g        = 0;
  event         chk_ev;

  function automatic logic [W-1:0] pack_exp(input logic c, input logic st, input int n);
    int n8;
    int n2;
    n8 = GC_EN ? ((n > 255) ? 255 : n) : 0;
    n2 = GC_EN ? ((n > 3) ? 3 : n) : 0;
    return {c, st, n8[7:0], n2[1:0]};
  endfunction

  // monitor
  always begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    string        nm;
    @(posedge clk or chk_ev);
    #2;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {a_clean, stable, gc, gc2};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got clean=%b stable=%b gc=%0d gc2=%0d, expected clean=%b stable=%b gc=%0d gc2=%0d",
                 nm, a[11], a[10], a[9:2], a[1:0], e[11], e[10], e[9:2], e[1:0]);
      end
    end
  end

  // drivers
  task automatic step(input logic raw, input logic ec, input logic es, input int eg, input string nm);
    @(negedge clk);
    a_raw = raw;
    exp_q.push_back(pack_exp(ec, es, eg));
    name_q.push_back(nm);
  endtask

  task automatic clean_edge(input logic to, input string nm);
    logic fr;
    fr = ~to;
    step(to, fr, 1'b1, g, nm);
    step(to, fr, 1'b1, g, nm);
    step(to, fr, 1'b0, g, nm);
    step(to, fr, 1'b0, g, nm);
    step(to, fr, 1'b0, g, nm);
    step(to, to, 1'b1, g, nm);
    step(to, to, 1'b1, g, nm);
  endtask

  task automatic glitch_pulse(input string nm);
    step(1'b1, 1'b0, 1'b1, g, nm);
    step(1'b1, 1'b0, 1'b1, g, nm);
    step(1'b1, 1'b0, 1'b0, g, nm);
    step(1'b0, 1'b0, 1'b0, g, nm);
    step(1'b0, 1'b0, 1'b0, g, nm);
    g++;
    step(1'b0, 1'b0, 1'b1, g, nm);
    step(1'b0, 1'b0, 1'b1, g, nm);
  endtask

  task automatic async_check(input logic ec, input logic es, input int eg, input string nm);
    exp_q.push_back(pack_exp(ec, es, eg));
    name_q.push_back(nm);
    -> chk_ev;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // asynchronous reset before any clock edge
    #2;
    rst_n = 1'b0;
    async_check(1'b0, 1'b1, 0, "reset_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step(1'b0, 1'b0, 1'b1, g, "idle");
    step(1'b0, 1'b0, 1'b1, g, "idle");

    clean_edge(1'b1, "clean_rise");
    clean_edge(1'b0, "clean_fall");

    // five 3-cycle glitches: narrow counter reads 1,2,3,3,3
    for (int i = 0; i < 5; i++) glitch_pulse("glitch_sat");

    // bounce burst: toggles for 20 cycles, then holds high
    for (int k = 0; k < 26; k++) begin
      logic raw, ec, es;
      int   eg;
      raw = (k < 20) ? (k % 2 == 0) : 1'b1;
      ec  = (k >= 25);
      if (k < 2)       es = 1'b1;
      else if (k < 22) es = (k % 2 == 1);
      else if (k < 25) es = 1'b0;
      else             es = 1'b1;
      eg = g + ((k >= 3) ? (((k > 21) ? 21 : k) - 1) / 2 : 0);
      step(raw, ec, es, eg, "bounce_burst");
    end
    g = g + 10;
    step(1'b1, 1'b1, 1'b1, g, "burst_hold");
    clean_edge(1'b0, "burst_fall");

    // reset while a candidate is being qualified
    step(1'b1, 1'b0, 1'b1, g, "rmc_pre");
    step(1'b1, 1'b0, 1'b1, g, "rmc_pre");
    step(1'b1, 1'b0, 1'b0, g, "rmc_check");
    @(negedge clk);
    rst_n = 1'b0;
    g     = 0;
    async_check(1'b0, 1'b1, 0, "reset_mid_check");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clean_edge(1'b1, "post_reset_rise");

    @(posedge clk);
    #4;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
